pwm_level_mux: RTL and testbench
================================

# pwm_level_mux

Parametrised, glitch-free PWM level selector for the light-stand output stage. It picks one of `CH` PWM brightness channels, or off, and drives a single registered LED drive line. Level changes come from a direct load or a step button pulse. They are held pending and only take effect at a PWM period boundary, so no runt or stretched pulse reaches the LED. It sits between the per-level PWM generators and the LED pin, under the light-stand FSM.

## Interface
Parameters:
- `CH`, default 4: number of PWM input channels (≥1).
- `SEL_W`, default 3: selection code width. Must satisfy 2^SEL_W > CH.

Ports (clock and reset first):
- `i_clk`, in, 1: system clock. Single clock domain.
- `i_reset_n`, in, 1: reset, synchronous, active-low. Sampled on the rising edge of `i_clk`.
- `i_pwm`, in, CH: PWM channels. Bit k is level k+1.
- `i_period_end`, in, 1: one-cycle strobe on the last clock of a PWM period. Shared by all channels.
- `i_load`, in, 1: load `i_sel` into the pending level.
- `i_sel`, in, SEL_W: direct level code. 0 = off, 1..CH = channel.
- `i_step`, in, 1: one-cycle pulse. Advances the pending level cyclically.
- `o_pwm`, out, 1: registered LED drive.
- `o_level`, out, SEL_W: currently active level.
- `o_pending`, out, 1: high while the pending level ≠ the active level.

## Operation
- Two registers: `nxt` (pending level) and `lvl` (active level, driven on `o_level`).
- Level code 0 forces `o_pwm` low. Code k (1..CH) routes `i_pwm[k-1]`.
- Updating `nxt`:
  - `i_load`: `nxt` ← `i_sel`. If `i_sel` > CH, `nxt` ← 0 (out-of-range means off, never X).
  - `i_step` without `i_load`: `nxt` ← (`nxt` == CH) ? 0 : `nxt`+1. The sequence is 0,1,…,CH,0.
  - `i_load` and `i_step` in the same cycle: `i_load` wins and the step is dropped.
  - Several steps before one commit accumulate.
- Commit: on `i_period_end`, `lvl` ← next value of `nxt`. A load or step in the same cycle as `i_period_end` is committed in that cycle.
- Derived states:
  - IDLE: `lvl` == `nxt`.
  - PENDING: `lvl` ≠ `nxt`.
  - IDLE→PENDING on a load or step that changes `nxt` without `i_period_end`.
  - PENDING→IDLE on `i_period_end`.
  - A load or step that lands back on `lvl` returns to IDLE with no commit.
- `o_pending` = (`lvl` ≠ `nxt`), registered along with `lvl` and `nxt`.
- Reset, while `i_reset_n` is low at a clock edge: `lvl` = 0, `nxt` = 0, `o_pwm` = 0, `o_level` = 0, `o_pending` = 0. Any pending change is discarded, including a reset in the middle of a period.

## Timing
- `o_pwm` is registered: `o_pwm`(t+1) = selected `i_pwm` bit at t, using the `lvl` value being written at t. This gives exactly one cycle of latency.
- The first cycle after the `i_period_end` cycle already carries the new channel. The cycle with `i_period_end` still carries the old one.
- `o_level` and `o_pending` update on the same edge as the commit.
- `i_step` is edge-agnostic: each high cycle is one step. Debounce and one-shot happen upstream.
- No combinational path from any input to any output.

## Structure
- Shared package `pwm_pkg`:
  - `LVL_OFF` = 0.
  - A clog2 helper for deriving `SEL_W` from `CH`.
  - The period-strobe convention (strobe on the last cycle of a period).
- Sub-module `level_step_ctrl`: owns `nxt`, the load/step priority and the range clamp. Outputs `nxt` and its next value.
- Top level: commit register, channel mux, output register.

## Test plan
- Reset release:
  - Stimulus: `CH`=4, all `i_pwm`=1, `i_reset_n` held low 3 cycles, then high.
  - Required: `o_pwm`=0, `o_level`=0 and `o_pending`=0 throughout, and still 0 one cycle after release.
- Step wrap:
  - Stimulus: five `i_step` pulses, each followed by `i_period_end`.
  - Required: `o_level` goes 1,2,3,4,0.
  - Required: `o_pwm` follows `i_pwm[0..3]` one cycle late, then is low.
- Deferred commit:
  - Stimulus: `i_load`, `i_sel`=3 mid-period.
  - Required: `o_pending`=1 and `o_pwm` still tracks the old channel.
  - Required: after `i_period_end`, `o_level`=3 and `o_pwm`=`i_pwm[2]` delayed one cycle.
- Collisions:
  - Stimulus: `i_load` (`i_sel`=2) together with `i_step`.
  - Required: `nxt`=2, the step is dropped.
  - Stimulus: a load in the same cycle as `i_period_end`.
  - Required: committed immediately, `o_pending` stays 0.
- Out of range:
  - Stimulus: `i_sel`=6 or 7 with `CH`=4.
  - Required: after commit, `o_level`=0 and `o_pwm`=0.
- Reset mid-operation:
  - Stimulus: load 4 (pending), then reset before `i_period_end`.
  - Required: `o_level`=0, `o_pending`=0, and a later `i_period_end` leaves the level at 0.
- Parametric run:
  - Stimulus: `CH`=7, `SEL_W`=3; step through all levels.
  - Required: sequence 0..7 then back to 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM level selector: level codes, width helper,
// period-strobe convention and the pending/idle state encoding.
package pwm_pkg;

  localparam int LVL_OFF = 0;

  // Period strobe is asserted on the last clock of a PWM period; commits use it.
  localparam bit PERIOD_STROBE_ON_LAST = 1'b1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } lvl_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Codes 0..ch must all be representable.
  function automatic int sel_width(input int ch);
    return (clog2(ch + 1) < 1) ? 1 : clog2(ch + 1);
  endfunction

endpackage

// File: rtl/pwm_level_mux_if.sv
// Level-change control bundle: direct load with code, and step pulse.
interface pwm_level_mux_if #(
  parameter int SEL_W = 3
);
  logic             load;
  logic [SEL_W-1:0] sel;
  logic             step;

  modport master (output load, sel, step);
  modport slave  (input  load, sel, step);
endinterface

// File: rtl/pwm_level_mux_level_step_ctrl.sv
// Pending-level register: load beats step, out-of-range loads clamp to off,
// steps wrap CH -> 0.
module level_step_ctrl
  import pwm_pkg::*;
#(
  parameter int CH    = 4,
  parameter int SEL_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  pwm_level_mux_if.slave   ctrl,
  output logic [SEL_W-1:0] o_nxt,
  output logic [SEL_W-1:0] o_nxt_d
);

  localparam logic [SEL_W-1:0] CH_CODE  = SEL_W'(CH);
  localparam logic [SEL_W-1:0] OFF_CODE = SEL_W'(LVL_OFF);

  logic [SEL_W-1:0] r_nxt;
  logic [SEL_W-1:0] w_nxt_d;

  always_comb begin
    w_nxt_d = r_nxt;
    if (ctrl.load) begin
      w_nxt_d = (ctrl.sel > CH_CODE) ? OFF_CODE : ctrl.sel;
    end else if (ctrl.step) begin
      w_nxt_d = (r_nxt == CH_CODE) ? OFF_CODE : r_nxt + SEL_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_nxt <= OFF_CODE;
    else            r_nxt <= w_nxt_d;
  end

  assign o_nxt   = r_nxt;
  assign o_nxt_d = w_nxt_d;

endmodule

// File: rtl/pwm_level_mux.sv
// Glitch-free PWM level selector: level changes are held pending and
// committed on the period strobe; LED drive is registered.
module pwm_level_mux
  import pwm_pkg::*;
#(
  parameter int CH    = 4,
  parameter int SEL_W = sel_width(CH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [CH-1:0]    i_pwm,
  input  logic             i_period_end,
  input  logic             i_load,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_step,
  output logic             o_pwm,
  output logic [SEL_W-1:0] o_level,
  output logic             o_pending
);

  pwm_level_mux_if #(.SEL_W(SEL_W)) u_ctrl_if ();

  assign u_ctrl_if.load = i_load;
  assign u_ctrl_if.sel  = i_sel;
  assign u_ctrl_if.step = i_step;

  logic [SEL_W-1:0] w_nxt;
  logic [SEL_W-1:0] w_nxt_d;
  logic [SEL_W-1:0] w_lvl_d;
  logic             w_pwm_sel;

  logic [SEL_W-1:0] r_lvl;
  logic             r_pwm;
  lvl_state_e       r_state;

  level_step_ctrl #(
    .CH    (CH),
    .SEL_W (SEL_W)
  ) u_step_ctrl (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .ctrl      (u_ctrl_if.slave),
    .o_nxt     (w_nxt),
    .o_nxt_d   (w_nxt_d)
  );

  // A load/step in the strobe cycle commits in that same cycle.
  assign w_lvl_d = i_period_end ? w_nxt_d : r_lvl;

  // Mux on the level being written so the new channel appears one cycle later.
  always_comb begin
    w_pwm_sel = 1'b0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (w_lvl_d == SEL_W'(k + 1)) w_pwm_sel = i_pwm[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_lvl   <= SEL_W'(LVL_OFF);
      r_pwm   <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_lvl   <= w_lvl_d;
      r_pwm   <= w_pwm_sel;
      r_state <= (w_lvl_d != w_nxt_d) ? ST_PENDING : ST_IDLE;
    end
  end

  assign o_pwm     = r_pwm;
  assign o_level   = r_lvl;
  assign o_pending = (r_state == ST_PENDING);

endmodule

// File: tb/tb_pwm_level_mux.sv
// Directed self-checking bench for pwm_level_mux (CH=4 and CH=7 instances).
module tb_pwm_level_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] pwm4;
  logic       pe4;
  logic [6:0] pwm7;
  logic       pe7;
  logic       o_pwm4, o_pend4, o_pwm7, o_pend7;
  logic [2:0] o_lvl4, o_lvl7;

  int checks = 0;
  int errors = 0;

  pwm_level_mux_if #(.SEL_W(3)) if4 ();
  pwm_level_mux_if #(.SEL_W(3)) if7 ();

  pwm_level_mux #(.CH(4), .SEL_W(3)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_pwm(pwm4), .i_period_end(pe4),
    .i_load(if4.load), .i_sel(if4.sel), .i_step(if4.step),
    .o_pwm(o_pwm4), .o_level(o_lvl4), .o_pending(o_pend4)
  );

  pwm_level_mux #(.CH(7), .SEL_W(3)) dut7 (
    .i_clk(clk), .i_reset_n(rst_n), .i_pwm(pwm7), .i_period_end(pe7),
    .i_load(if7.load), .i_sel(if7.sel), .i_step(if7.step),
    .o_pwm(o_pwm7), .o_level(o_lvl7), .o_pending(o_pend7)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of CH=4 inputs and advance past the edge.
  task automatic drive4(input logic ld, input logic [2:0] sel, input logic st,
                        input logic pe, input logic [3:0] pw);
    if4.load = ld; if4.sel = sel; if4.step = st; pe4 = pe; pwm4 = pw;
    tick();
  endtask

  task automatic chk4(input string name, input logic pw, input logic [2:0] lvl,
                      input logic pend);
    checks++;
    if (o_pwm4 !== pw || o_lvl4 !== lvl || o_pend4 !== pend) begin
      errors++;
      $display("FAIL %s: got pwm=%b lvl=%0d pend=%b, want pwm=%b lvl=%0d pend=%b",
               name, o_pwm4, o_lvl4, o_pend4, pw, lvl, pend);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive4(1'b0, 3'd0, 1'b0, 1'b0, 4'hF);
      chk4("reset_hold", 1'b0, 3'd0, 1'b0);
    end
    rst_n = 1'b1;
    drive4(1'b0, 3'd0, 1'b0, 1'b0, 4'hF);
    chk4("reset_release", 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_step_wrap();
    logic [2:0] exp_lvl;
    logic [3:0] onehot;
    for (int i = 0; i < 5; i++) begin
      exp_lvl = 3'((i + 1) % 5);
      onehot  = (exp_lvl == 3'd0) ? 4'hF : (4'b0001 << (exp_lvl - 3'd1));
      drive4(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);
      chk4("step_pending", 1'b0, 3'(i), 1'b1);
      drive4(1'b0, 3'd0, 1'b0, 1'b1, onehot);
      chk4("step_commit", exp_lvl != 3'd0, exp_lvl, 1'b0);
      drive4(1'b0, 3'd0, 1'b0, 1'b0, ~onehot);
      chk4("step_other_bits", 1'b0, exp_lvl, 1'b0);
    end
  endtask

  task automatic test_deferred();
    drive4(1'b1, 3'd1, 1'b0, 1'b1, 4'b0001);
    chk4("defer_setup", 1'b1, 3'd1, 1'b0);
    drive4(1'b1, 3'd3, 1'b0, 1'b0, 4'b0001);
    chk4("defer_old_ch_hi", 1'b1, 3'd1, 1'b1);
    drive4(1'b0, 3'd0, 1'b0, 1'b0, 4'b0100);
    chk4("defer_old_ch_lo", 1'b0, 3'd1, 1'b1);
    drive4(1'b0, 3'd0, 1'b0, 1'b1, 4'b0100);
    chk4("defer_commit", 1'b1, 3'd3, 1'b0);
    drive4(1'b0, 3'd0, 1'b0, 1'b0, 4'b1011);
    chk4("defer_new_ch_lo", 1'b0, 3'd3, 1'b0);
  endtask

  task automatic test_collision();
    drive4(1'b1, 3'd2, 1'b1, 1'b0, 4'h0);
    chk4("coll_load_step_pend", 1'b0, 3'd3, 1'b1);
    drive4(1'b0, 3'd0, 1'b0, 1'b1, 4'b0010);
    chk4("coll_load_wins", 1'b1, 3'd2, 1'b0);
    drive4(1'b1, 3'd4, 1'b0, 1'b1, 4'b1000);
    chk4("coll_load_with_pe", 1'b1, 3'd4, 1'b0);
    drive4(1'b1, 3'd4, 1'b0, 1'b0, 4'b0000);
    chk4("coll_load_same_lvl", 1'b0, 3'd4, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive4(1'b1, 3'd0, 1'b0, 1'b1, 4'h0);
    chk4("b2b_zero", 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) drive4(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);
    chk4("b2b_steps_pending", 1'b0, 3'd0, 1'b1);
    drive4(1'b0, 3'd0, 1'b0, 1'b1, 4'b0100);
    chk4("b2b_accumulated", 1'b1, 3'd3, 1'b0);
    drive4(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);
    drive4(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);
    chk4("b2b_land_on_lvl_pre", 1'b0, 3'd3, 1'b1);
    drive4(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);
    drive4(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);
    drive4(1'b0, 3'd0, 1'b1, 1'b0, 4'h0);
    chk4("b2b_land_on_lvl_idle", 1'b0, 3'd3, 1'b0);
  endtask

  task automatic test_out_of_range();
    for (int s = 6; s <= 7; s++) begin
      drive4(1'b1, 3'd1, 1'b0, 1'b1, 4'hF);
      chk4("oor_setup", 1'b1, 3'd1, 1'b0);
      drive4(1'b1, 3'(s), 1'b0, 1'b0, 4'hF);
      chk4("oor_pending", 1'b1, 3'd1, 1'b1);
      drive4(1'b0, 3'd0, 1'b0, 1'b1, 4'hF);
      chk4("oor_commit_off", 1'b0, 3'd0, 1'b0);
    end
    drive4(1'b1, 3'd5, 1'b0, 1'b1, 4'hF);
    chk4("oor_sel5", 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive4(1'b1, 3'd1, 1'b0, 1'b1, 4'hF);
    chk4("rmid_setup", 1'b1, 3'd1, 1'b0);
    drive4(1'b1, 3'd4, 1'b0, 1'b0, 4'hF);
    chk4("rmid_pending", 1'b1, 3'd1, 1'b1);
    rst_n = 1'b0;
    drive4(1'b0, 3'd0, 1'b0, 1'b0, 4'hF);
    chk4("rmid_in_reset", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;
    drive4(1'b0, 3'd0, 1'b0, 1'b1, 4'hF);
    chk4("rmid_pe_after", 1'b0, 3'd0, 1'b0);
    drive4(1'b0, 3'd0, 1'b0, 1'b0, 4'hF);
    chk4("rmid_settled", 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_param7();
    logic [2:0] exp_lvl;
    pwm7 = 7'h7F;
    for (int i = 0; i < 8; i++) begin
      exp_lvl = 3'((i + 1) % 8);
      if7.step = 1'b1; pe7 = 1'b0;
      tick();
      if7.step = 1'b0; pe7 = 1'b1;
      tick();
      pe7 = 1'b0;
      checks++;
      if (o_lvl7 !== exp_lvl || o_pend7 !== 1'b0 || o_pwm7 !== (exp_lvl != 3'd0)) begin
        errors++;
        $display("FAIL param7_step%0d: got lvl=%0d pend=%b pwm=%b, want lvl=%0d pend=0 pwm=%b",
                 i, o_lvl7, o_pend7, o_pwm7, exp_lvl, exp_lvl != 3'd0);
      end
    end
    if7.load = 1'b1; if7.sel = 3'd7; pe7 = 1'b1; pwm7 = 7'b0111111;
    tick();
    if7.load = 1'b0; pe7 = 1'b0;
    checks++;
    if (o_lvl7 !== 3'd7 || o_pwm7 !== 1'b0) begin
      errors++;
      $display("FAIL param7_load7: got lvl=%0d pwm=%b, want lvl=7 pwm=0", o_lvl7, o_pwm7);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if4.load = 1'b0; if4.sel = '0; if4.step = 1'b0; pe4 = 1'b0; pwm4 = '0;
    if7.load = 1'b0; if7.sel = '0; if7.step = 1'b0; pe7 = 1'b0; pwm7 = '0;
    test_reset();
    test_step_wrap();
    test_deferred();
    test_collision();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_param7();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
